// File: rtl/line_rd_pkg.sv
// Shared types and width helpers for the two-port cache-line read arbiter.
package line_rd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } rd_state_e;

    localparam int unsigned OFFSET_LEN_DEF = 6;

    function automatic int unsigned line_w(input int unsigned offset_len);
        return 32'(1) << (offset_len + 3);
    endfunction

    function automatic int unsigned word_sel_w(input int unsigned offset_len);
        return offset_len - 2;
    endfunction

    localparam int unsigned LINE_W     = line_w(OFFSET_LEN_DEF);
    localparam int unsigned WORD_SEL_W = word_sel_w(OFFSET_LEN_DEF);

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/line_word_sel.sv
// Combinational pick of one 32-bit word out of a cache line by word offset.
module line_word_sel
    import line_rd_pkg::*;
#(
    parameter int unsigned OFFSET_LEN = 6,
    parameter int unsigned WORD_W     = 32
) (
    input  logic [line_w(OFFSET_LEN)-1:0]     i_line,
    input  logic [word_sel_w(OFFSET_LEN)-1:0] i_sel,
    output logic [WORD_W-1:0]                 o_word
);

    localparam int unsigned SW        = word_sel_w(OFFSET_LEN);
    localparam int unsigned NUM_WORDS = line_w(OFFSET_LEN) / WORD_W;

    always_comb begin
        o_word = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (i_sel == SW'(k)) begin
                o_word = i_line[k*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/line_rd_arbiter.sv
// Round-robin two-port scheduler for a shared cache-line read port.
// Define LINE_RD_BYPASS_EN to add a last-line buffer that answers repeat-line hits directly.
module line_rd_arbiter
    import line_rd_pkg::*;
#(
    parameter int unsigned OFFSET_LEN = 6,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         req0_valid,
    input  logic [ADDR_W-1:0]            req0_addr,
    output logic                         req0_ready,
    output logic                         resp0_valid,
    output logic [WORD_W-1:0]            resp0_data,
    input  logic                         req1_valid,
    input  logic [ADDR_W-1:0]            req1_addr,
    output logic                         req1_ready,
    output logic                         resp1_valid,
    output logic [WORD_W-1:0]            resp1_data,
    output logic                         mem_en,
    output logic [ADDR_W-OFFSET_LEN-1:0] mem_addr,
    input  logic                         mem_rvalid,
    input  logic [line_w(OFFSET_LEN)-1:0] mem_rdata
);

    localparam int unsigned LW = line_w(OFFSET_LEN);
    localparam int unsigned SW = word_sel_w(OFFSET_LEN);

    rd_state_e         r_state;
    rd_state_e         w_state_d;
    logic              r_last_grant;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data0;
    logic [WORD_W-1:0] r_data1;

    logic              w_any;
    logic              w_gnt_port;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_hs;
    logic              w_hit;
    logic              w_load;
    logic              w_load_port;
    logic [LW-1:0]     w_sel_line;
    logic [SW-1:0]     w_sel_off;
    logic [WORD_W-1:0] w_word;
    logic              w_unused_addr;

    // On a tie the port that did not win last time is granted.
    assign w_any      = req0_valid | req1_valid;
    assign w_gnt_port = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_gnt_addr = w_gnt_port ? req1_addr : req0_addr;
    assign w_hs       = (r_state == StIdle) & w_any;

`ifdef LINE_RD_BYPASS_EN
    logic [LW-1:0]                r_buf;
    logic [ADDR_W-OFFSET_LEN-1:0] r_tag;
    logic                         r_buf_vld;

    assign w_hit      = w_hs & r_buf_vld & (w_gnt_addr[ADDR_W-1:OFFSET_LEN] == r_tag);
    // The selector serves the buffer in IDLE and the memory return otherwise.
    assign w_sel_line = (r_state == StIdle) ? r_buf : mem_rdata;
    assign w_sel_off  = (r_state == StIdle) ? w_gnt_addr[OFFSET_LEN-1:2]
                                            : r_addr[OFFSET_LEN-1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf     <= '0;
            r_tag     <= '0;
            r_buf_vld <= 1'b0;
        end else if ((r_state == StWait) && mem_rvalid) begin
            r_buf     <= mem_rdata;
            r_tag     <= r_addr[ADDR_W-1:OFFSET_LEN];
            r_buf_vld <= 1'b1;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_sel_line = mem_rdata;
    assign w_sel_off  = r_addr[OFFSET_LEN-1:2];
`endif

    line_word_sel #(
        .OFFSET_LEN (OFFSET_LEN),
        .WORD_W     (WORD_W)
    ) u_word_sel (
        .i_line (w_sel_line),
        .i_sel  (w_sel_off),
        .o_word (w_word)
    );

    assign w_load      = ((r_state == StWait) & mem_rvalid) | w_hit;
    assign w_load_port = (r_state == StIdle) ? w_gnt_port : r_port;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_hs) w_state_d = w_hit ? StResp : StIssue;
            StIssue: w_state_d = StWait;
            StWait:  if (mem_rvalid) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_last_grant <= PORT_MEM;
            r_port       <= PORT_IF;
            r_addr       <= '0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_hs) begin
                r_addr       <= w_gnt_addr;
                r_port       <= w_gnt_port;
                r_last_grant <= w_gnt_port;
            end
            if (w_load && (w_load_port == PORT_IF)) begin
                r_data0 <= w_word;
            end
            if (w_load && (w_load_port == PORT_MEM)) begin
                r_data1 <= w_word;
            end
        end
    end

    // Byte lane bits are latched with the address but never used.
    assign w_unused_addr = ^r_addr[1:0];

    assign req0_ready  = w_hs & (w_gnt_port == PORT_IF);
    assign req1_ready  = w_hs & (w_gnt_port == PORT_MEM);
    assign mem_en      = (r_state == StIssue);
    assign mem_addr    = r_addr[ADDR_W-1:OFFSET_LEN];
    assign resp0_valid = (r_state == StResp) & (r_port == PORT_IF);
    assign resp1_valid = (r_state == StResp) & (r_port == PORT_MEM);
    assign resp0_data  = r_data0;
    assign resp1_data  = r_data1;

endmodule

// File: tb/tb_line_rd_arbiter.sv
// Self-checking bench for line_rd_arbiter: directed table, corner sequences, random traffic.
module tb_line_rd_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned TAG_W  = 26;
`ifdef LINE_RD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic              req0_ready;
    logic              resp0_valid;
    logic [31:0]       resp0_data;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic              req1_ready;
    logic              resp1_valid;
    logic [31:0]       resp1_data;
    logic              mem_en;
    logic [TAG_W-1:0]  mem_addr;
    logic              mem_rvalid = 1'b0;
    logic [LINE_W-1:0] mem_rdata = '0;

    line_rd_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_ready  (req0_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_ready  (req1_ready),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory contents: word k of line L.
    logic [31:0] salt = 32'h0;
    int          mem_lat = 1;
    bit          spur_tog = 1'b0;
    bit          spur_done = 1'b0;

    function automatic logic [31:0] mem_word(input logic [TAG_W-1:0] line, input logic [3:0] k);
        return 32'hA000_0000 + 32'(k) + salt * 32'(line);
    endfunction

    function automatic logic [LINE_W-1:0] make_line(input logic [TAG_W-1:0] line);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_word(line, 4'(k));
        return l;
    endfunction

    task automatic responder();
        logic [TAG_W-1:0] line;
        int               l;
        forever begin
            @(negedge clk);
            if (spur_tog != spur_done) begin
                spur_done = spur_tog;
                @(posedge clk); #1;
                mem_rvalid = 1'b1;
                mem_rdata  = {16{32'hDEAD_BEEF}};
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end else if (mem_en) begin
                line = mem_addr;
                l = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
                repeat (l) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = make_line(line);
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
    endtask

    // Transaction-level reference: at most one request outstanding, round-robin on ties.
    typedef struct {
        bit               port;
        logic [TAG_W-1:0] line;
        logic [31:0]      word;
        bit               hit;
        int               hs_cyc;
    } exp_t;

    exp_t             q[$];
    bit               grants[$];
    bit               m_last = 1'b1;
    int               m_out = 0;
    bit               m_bvld = 1'b0;
    logic [TAG_W-1:0] m_bline = '0;
    int               mem_seen = 0;
    int               cyc = 0;
    int               mem_en_cyc = 0;
    int               last_resp_cyc = 0;
    int               last_hs_cyc = 0;
    int               n_hs = 0;
    int               n_resp = 0;
    logic [TAG_W-1:0] last_mem_addr = '0;
    logic [31:0]      last_resp_data = '0;

    task automatic model_reset();
        q.delete();
        m_last   = 1'b1;
        m_out    = 0;
        m_bvld   = 1'b0;
        mem_seen = 0;
    endtask

    task automatic mon_cycle();
        bit          er0, er1, gp;
        exp_t        e;
        logic [31:0] a;
        cyc++;
        er0 = 1'b0;
        er1 = 1'b0;
        gp  = 1'b0;
        if (m_out == 0 && (req0_valid || req1_valid)) begin
            gp  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            er0 = ~gp;
            er1 = gp;
        end
        check("req0_ready", req0_ready, er0);
        check("req1_ready", req1_ready, er1);
        if (mem_en) begin
            mem_seen++;
            mem_en_cyc    = cyc;
            last_mem_addr = mem_addr;
            if (q.size() == 0) begin
                check("mem_en_idle", mem_en, 1'b0);
            end else begin
                check("mem_addr", mem_addr, q[0].line);
                check("mem_en_on_hit", mem_en, !q[0].hit);
                check("mem_en_timing", cyc, q[0].hs_cyc + 1);
            end
        end
        if (resp0_valid && resp1_valid) check("resp_both", resp1_valid, 1'b0);
        if (resp0_valid || resp1_valid) begin
            if (q.size() == 0) begin
                check("resp_unexpected", resp0_valid | resp1_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("resp_port", resp1_valid, e.port);
                last_resp_data = e.port ? resp1_data : resp0_data;
                check("resp_data", last_resp_data, e.word);
                check("mem_reads", mem_seen, e.hit ? 0 : 1);
                if (e.hit) check("hit_latency", cyc - e.hs_cyc, 1);
                else if (mem_lat != 0) check("miss_latency", cyc - e.hs_cyc, mem_lat + 2);
                last_resp_cyc = cyc;
                n_resp++;
                m_out    = 0;
                mem_seen = 0;
            end
        end
        if (er0 || er1) begin
            a        = gp ? req1_addr : req0_addr;
            e.port   = gp;
            e.line   = a[31:6];
            e.word   = mem_word(a[31:6], a[5:2]);
            e.hit    = BYP && m_bvld && (m_bline == e.line);
            e.hs_cyc = cyc;
            if (!e.hit) begin
                m_bvld  = BYP;
                m_bline = e.line;
            end
            q.push_back(e);
            grants.push_back(gp);
            m_last      = gp;
            m_out       = 1;
            mem_seen    = 0;
            last_hs_cyc = cyc;
            n_hs++;
        end
    endtask

    task automatic cycle_mon();
        @(negedge clk);
        mon_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
        check("rst_resp0_data", resp0_data, 32'h0);
        check("rst_resp1_data", resp1_data, 32'h0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_addr", mem_addr, 26'h0);
        repeat (n) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic request(input bit p, input logic [31:0] a);
        int h0;
        bit ok;
        h0 = n_hs;
        ok = 1'b0;
        if (p) begin req1_valid = 1'b1; req1_addr = a; end
        else   begin req0_valid = 1'b1; req0_addr = a; end
        for (int i = 0; i < 10 && !ok; i++) begin
            cycle_mon();
            if (n_hs != h0) ok = 1'b1;
        end
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        check("handshake_seen", ok, 1'b1);
    endtask

    task automatic wait_resp();
        int r0;
        r0 = n_resp;
        for (int i = 0; i < 40 && n_resp == r0; i++) cycle_mon();
        check("resp_seen", n_resp != r0, 1'b1);
    endtask

    typedef struct {
        bit               p;
        logic [31:0]      addr;
        int               lat;
        logic [TAG_W-1:0] line;
        logic [31:0]      word;
    } vec_t;

    vec_t tbl[5];
    bit   alt[4];
    int   h0;
    int   r0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'h0000_1044, 1, 26'h41,      32'hA000_0001};
        tbl[1] = '{1'b1, 32'h0000_2FFC, 3, 26'hBF,      32'hA000_000F};
        tbl[2] = '{1'b0, 32'h0000_0007, 2, 26'h0,       32'hA000_0001};
        tbl[3] = '{1'b1, 32'hFFFF_FFC8, 1, 26'h3FF_FFFF, 32'hA000_0002};
        tbl[4] = '{1'b0, 32'h1234_5678, 4, 26'h48_D159, 32'hA000_000E};
        alt    = '{1'b0, 1'b1, 1'b0, 1'b1};

        fork
            responder();
        join_none

        do_reset(2);

        for (int i = 0; i < 5; i++) begin
            mem_lat = tbl[i].lat;
            request(tbl[i].p, tbl[i].addr);
            wait_resp();
            check("tbl_mem_addr", last_mem_addr, tbl[i].line);
            check("tbl_word", last_resp_data, tbl[i].word);
            cycle_mon();
        end

        // Both ports held valid from reset: grants must alternate.
        do_reset(2);
        mem_lat = 2;
        grants.delete();
        h0 = n_hs;
        req0_valid = 1'b1; req0_addr = 32'h0000_0100;
        req1_valid = 1'b1; req1_addr = 32'h0000_02FC;
        for (int i = 0; i < 40 && n_hs < h0 + 4; i++) cycle_mon();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp();
        check("alt_handshakes", n_hs - h0, 4);
        for (int k = 0; k < 4; k++) check($sformatf("alt_grant%0d", k), grants[k], alt[k]);
        check("alt_resp0_word", resp0_data, 32'hA000_0000);
        check("alt_resp1_word", resp1_data, 32'hA000_000F);

        // Slow memory with port 1 waiting: accepted in the IDLE right after RESP.
        mem_lat = 10;
        request(1'b0, 32'h0000_3008);
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_4010;
        wait_resp();
        h0 = n_hs;
        for (int i = 0; i < 5 && n_hs == h0; i++) cycle_mon();
        req1_valid = 1'b0;
        check("late_accept_gap", last_hs_cyc - last_resp_cyc, 1);
        check("late_accept_port", grants[$], 1'b1);
        wait_resp();

        // Reset while waiting on memory; the stale line returns after reset.
        mem_lat = 7;
        request(1'b0, 32'h0000_5000);
        cycle_mon();
        cycle_mon();
        cycle_mon();
        r0 = n_resp;
        do_reset(2);
        for (int i = 0; i < 8; i++) cycle_mon();
        check("no_resp_after_reset", n_resp, r0);
        mem_lat = 1;
        request(1'b0, 32'h0000_1044);
        wait_resp();
        check("post_reset_word", resp0_data, 32'hA000_0001);

        // Spurious line return while idle.
        r0 = n_resp;
        spur_tog = ~spur_tog;
        for (int i = 0; i < 5; i++) cycle_mon();
        check("spurious_no_resp", n_resp, r0);
        request(1'b1, 32'h0000_1048);
        wait_resp();
        check("post_spur_word", resp1_data, 32'hA000_0002);

`ifdef LINE_RD_BYPASS_EN
        do_reset(2);
        mem_lat = 1;
        request(1'b0, 32'h0000_1044);
        wait_resp();
        request(1'b0, 32'h0000_1048);
        wait_resp();
        check("byp_hit_word", resp0_data, 32'hA000_0002);
        check("byp_hit_latency", last_resp_cyc - last_hs_cyc, 1);
        check("byp_hit_no_mem_en", mem_en_cyc < last_hs_cyc, 1'b1);
        request(1'b0, 32'h0000_2000);
        wait_resp();
        check("byp_miss_mem_en", mem_en_cyc, last_hs_cyc + 1);
        check("byp_miss_addr", last_mem_addr, 26'h80);
`endif

        // Random traffic over a few lines, random memory latency.
        do_reset(2);
        salt    = 32'h0000_0100;
        mem_lat = 0;
        for (int i = 0; i < 500; i++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_addr  = 32'h0001_0000 + ($urandom_range(0, 3) << 6) + $urandom_range(0, 63);
            req1_addr  = 32'h0001_0000 + ($urandom_range(0, 3) << 6) + $urandom_range(0, 63);
            cycle_mon();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 40 && m_out != 0; i++) cycle_mon();
        check("random_drain", m_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
